n101_qspi_flashwr: RTL and testbench
====================================

# n101_qspi_flashwr

QSPI flash program engine: accepts a page-program request (address, length) plus a byte stream of write data. It drives the shared QSPI link port through Write-Enable, Page-Program and Read-Status-Register polling, and reports completion. It is the write-side companion to the memory-mapped read path and arbitrates for the same link via `io_link_lock`.

## Interface
Parameters:
- `POLL_LIMIT`, 16'hFFFF: maximum status bytes read while WIP=1 before aborting with timeout.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clock` in 1: clock.
  - `reset_n` in 1: asynchronous active-low reset.
- `io_en` in 1: engine enable; sampled only in IDLE.
- `io_ctrl_proto` in 2: protocol for command/address/data phases (0 single, 1 dual, 2 quad).
- `io_ctrl_addr_len` in 3: address bytes, 1..4.
- `io_ctrl_wren_code` / `io_ctrl_prog_code` / `io_ctrl_rdsr_code` in 8 each: opcodes (system default 0x06/0x02/0x05).
- `io_ctrl_fmt_endian` in 1: passed to `io_link_fmt_endian`.
- `io_req_ready` out 1, `io_req_valid` in 1, `io_req_bits_addr` in 32, `io_req_bits_len` in 8: program request; the byte count is len+1 (1..256).
- `io_wdata_ready` out 1, `io_wdata_valid` in 1, `io_wdata_bits` in 8: write data stream.
- `io_done_valid` out 1, `io_done_bits_timeout` out 1: one-cycle completion pulse and abort flag.
- `io_busy` out 1: high in every state except IDLE.
- Link port, same semantics as the read path:
  - `io_link_tx_ready` in 1, `io_link_tx_valid` out 1, `io_link_tx_bits` out 8.
  - `io_link_rx_valid` in 1, `io_link_rx_bits` in 8.
  - `io_link_cnt` out 8, `io_link_fmt_proto` out 2, `io_link_fmt_endian` out 1, `io_link_fmt_iodir` out 1 (1 = tx).
  - `io_link_cs_set` out 1, `io_link_cs_clear` out 1, `io_link_cs_hold` out 1.
  - `io_link_active` in 1, `io_link_lock` out 1.

## Operation
- States:
  - IDLE (0). `io_req_ready = io_en`. On request handshake: latch addr and len, go to WREN.
  - WREN (1). Send wren_code.
  - WEND (2). Send nothing, CS released.
  - PCMD (3). Send prog_code.
  - PADDR (4). Send address bytes.
  - PDATA (5). Send write data.
  - PEND (6). Send nothing, CS released.
  - SRCMD (7). Send rdsr_code.
  - SRRD (8). Read status bytes.
  - SEND (9). Send nothing, CS released.
  - State register is 4 bits.
- A byte moves on the link when `tx_valid & tx_ready`.
- Transitions:
  - WREN→WEND on byte.
  - WEND→PCMD when `io_link_active==0`.
  - PCMD→PADDR on byte; load cnt = addr_len.
  - PADDR sends addr byte cnt-1 (MSB first, cnt==1 sends addr[7:0]), cnt-- per byte; on the last byte go to PDATA and load dcnt = len.
  - PDATA: `tx_valid = io_wdata_valid`, `tx_bits = io_wdata_bits`, `io_wdata_ready = tx_ready`. dcnt-- per byte; the byte sent with dcnt==0 goes to PEND.
  - PEND→SRCMD when link inactive; clear poll counter.
  - SRCMD→SRRD on byte.
  - SRRD: `tx_valid=1`, `tx_bits=0x00`, `iodir=0`, proto single. On `rx_valid`:
    - bit0 (WIP)=0: go to SEND.
    - Poll counter == POLL_LIMIT-1: set the timeout flag and go to SEND.
    - Otherwise increment the poll counter; CS stays held and the flash repeats the status.
  - SEND→IDLE when link inactive; pulse `io_done_valid` with `io_done_bits_timeout`.
- Protocol per phase:
  - WREN, PCMD, SRCMD, SRRD are always single.
  - PADDR and PDATA use `io_ctrl_proto`.
  - `io_link_cnt` = 8/4/2 for proto 0/1/2, and 0 for proto 3.
- Chip select:
  - `io_link_cs_set=1` and `io_link_cs_hold=1` constantly.
  - `io_link_cs_clear=1` only in IDLE (on the accept cycle), WEND, PEND and SEND.
- `io_link_lock=1` in all states except IDLE.
- Write data is not page-boundary checked: the flash wraps in-page and the requester must split at 256-byte boundaries.
- `io_en` deasserted mid-operation has no effect; the operation completes.
- `io_wdata` starvation in PDATA stalls indefinitely with CS held.

## Timing
- Reset values: state IDLE, all counters 0, timeout flag 0. Outputs are `tx_valid=0`, `done_valid=0`, `busy=0`, `lock=0`, `cs_clear=0`; `io_req_ready` follows `io_en`.
- First `tx_valid` (wren_code) appears the cycle after request acceptance.
- Outputs are combinational from state and counters; no output registers.
- Each END state lasts at least 1 cycle; it exits on the first cycle with `io_link_active==0`.
- `io_done_valid` is high exactly one cycle, coincident with the SEND→IDLE transition. A new request can be accepted the following cycle.
- A single-cycle `rx_valid` and `tx_ready` in SRRD are handled independently: counting is on `rx_valid` only.
- Reset assertion mid-operation returns to IDLE immediately. The link sees `lock` and `tx_valid` drop, and no `done` is issued.

## Structure
- Shared header `n101_qspi_defines.v`: proto encodings, state encodings, default opcodes 0x06/0x02/0x05, WIP bit index.
- Sub-module `n101_qspi_bytecnt` (loadable 8-bit down counter with `last` flag) is instantiated twice: address/data count and poll count (16-bit variant via width parameter).

## Test plan
- addr 0x00123456, len 3, addr_len 3, proto 0; status 0x03 then 0x00 → tx bytes 06 | 02 12 34 56 d0..d3 | 05 00 00; `done_valid` with timeout=0; three `cs_clear` windows.
- proto 2 (quad), addr_len 4, len 0 → `io_link_cnt=2` in PADDR/PDATA and 8 in command phases; 4 address bytes MSB first; single data byte.
- `io_wdata_valid` low for 5 cycles mid-PDATA → `tx_valid` low, no byte lost, dcnt unchanged, CS held.
- POLL_LIMIT=4, status always 0x01 → exactly 4 status reads, then SEND, `done_valid=1`, `timeout=1`.
- `io_link_active` held high 10 cycles in WEND → WEND persists, `tx_valid=0`; PCMD is entered on the cycle active falls.
- `reset_n` pulsed low during PADDR → state IDLE, lock=0, `io_req_ready=io_en`; next request runs normally from WREN.

Source files
------------

// File: rtl/n101_qspi_flashwr_pkg.sv
// Shared constants for the QSPI flash program engine: link protocol codes,
// engine state encodings, default flash opcodes and small helper functions.
package n101_qspi_flashwr_pkg;

    localparam logic [1:0] ProtoSingle = 2'd0;
    localparam logic [1:0] ProtoDual   = 2'd1;
    localparam logic [1:0] ProtoQuad   = 2'd2;

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StWren  = 4'd1;
    localparam logic [3:0] StWend  = 4'd2;
    localparam logic [3:0] StPcmd  = 4'd3;
    localparam logic [3:0] StPaddr = 4'd4;
    localparam logic [3:0] StPdata = 4'd5;
    localparam logic [3:0] StPend  = 4'd6;
    localparam logic [3:0] StSrcmd = 4'd7;
    localparam logic [3:0] StSrrd  = 4'd8;
    localparam logic [3:0] StSend  = 4'd9;

    localparam logic [7:0] DefWrenCode = 8'h06;
    localparam logic [7:0] DefProgCode = 8'h02;
    localparam logic [7:0] DefRdsrCode = 8'h05;

    // Write-in-progress flag position in the status register
    localparam int unsigned WipBit = 0;

    // Link clocks needed to move one byte for a given lane width
    function automatic logic [7:0] proto_cnt(input logic [1:0] proto);
        case (proto)
            ProtoSingle: proto_cnt = 8'd8;
            ProtoDual:   proto_cnt = 8'd4;
            ProtoQuad:   proto_cnt = 8'd2;
            default:     proto_cnt = 8'd0;
        endcase
    endfunction

    // Address byte still to send when idx bytes remain (idx 1 -> addr[7:0], 4 wraps to 0)
    function automatic logic [7:0] addr_byte(input logic [31:0] addr, input logic [7:0] idx);
        case (idx[1:0])
            2'd1:    addr_byte = addr[7:0];
            2'd2:    addr_byte = addr[15:8];
            2'd3:    addr_byte = addr[23:16];
            default: addr_byte = addr[31:24];
        endcase
    endfunction

endpackage

// File: rtl/n101_qspi_bytecnt.sv
// Loadable down counter with a last flag (count == 0); load wins over decrement.
module n101_qspi_bytecnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             last_o
);

    logic [Width-1:0] count_q, count_d;

    // Next count: reload, decrement or hold
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - Width'(1);
        end
    end

    // Count register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == '0);

endmodule

// File: rtl/n101_qspi_flashwr.sv
// QSPI page-program engine: Write-Enable, Page-Program (cmd/addr/data), then
// Read-Status polling until WIP clears or the poll budget runs out.
module n101_qspi_flashwr
    import n101_qspi_flashwr_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        io_en,
    input  logic [1:0]  io_ctrl_proto,
    input  logic [2:0]  io_ctrl_addr_len,
    input  logic [7:0]  io_ctrl_wren_code,
    input  logic [7:0]  io_ctrl_prog_code,
    input  logic [7:0]  io_ctrl_rdsr_code,
    input  logic        io_ctrl_fmt_endian,
    output logic        io_req_ready,
    input  logic        io_req_valid,
    input  logic [31:0] io_req_bits_addr,
    input  logic [7:0]  io_req_bits_len,
    output logic        io_wdata_ready,
    input  logic        io_wdata_valid,
    input  logic [7:0]  io_wdata_bits,
    output logic        io_done_valid,
    output logic        io_done_bits_timeout,
    output logic        io_busy,
    input  logic        io_link_tx_ready,
    output logic        io_link_tx_valid,
    output logic [7:0]  io_link_tx_bits,
    input  logic        io_link_rx_valid,
    input  logic [7:0]  io_link_rx_bits,
    output logic [7:0]  io_link_cnt,
    output logic [1:0]  io_link_fmt_proto,
    output logic        io_link_fmt_endian,
    output logic        io_link_fmt_iodir,
    output logic        io_link_cs_set,
    output logic        io_link_cs_clear,
    output logic        io_link_cs_hold,
    input  logic        io_link_active,
    output logic        io_link_lock
);

    localparam logic [15:0] PollLoad = 16'(POLL_LIMIT - 1);

    logic [3:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic        timeout_q, timeout_d;
    logic [1:0]  phase_proto;

    logic        cnt_load, cnt_dec, cnt_last;
    logic [7:0]  cnt_load_val, cnt_val;
    logic        poll_load, poll_dec, poll_last;
    logic [15:0] poll_val;

    // Address bytes remaining, then data bytes remaining
    n101_qspi_bytecnt #(.Width(8)) u_byte_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_val),
        .last_o     (cnt_last)
    );

    // Status reads left before giving up; loaded with POLL_LIMIT-1 so last == final read
    n101_qspi_bytecnt #(.Width(16)) u_poll_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (poll_load),
        .load_val_i (PollLoad),
        .dec_i      (poll_dec),
        .count_o    (poll_val),
        .last_o     (poll_last)
    );

    logic unused_sig;
    assign unused_sig = ^{io_link_rx_bits, poll_val};

    // Next-state, counter control and combinational link outputs
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        len_d            = len_q;
        timeout_d        = timeout_q;
        cnt_load         = 1'b0;
        cnt_load_val     = 8'd0;
        cnt_dec          = 1'b0;
        poll_load        = 1'b0;
        poll_dec         = 1'b0;
        phase_proto      = ProtoSingle;
        io_req_ready     = 1'b0;
        io_wdata_ready   = 1'b0;
        io_done_valid    = 1'b0;
        io_link_tx_valid = 1'b0;
        io_link_tx_bits  = 8'h00;
        io_link_fmt_iodir = 1'b1;
        io_link_cs_clear = 1'b0;

        case (state_q)
            StIdle: begin
                io_req_ready = io_en;
                if (io_en && io_req_valid) begin
                    addr_d           = io_req_bits_addr;
                    len_d            = io_req_bits_len;
                    timeout_d        = 1'b0;
                    io_link_cs_clear = 1'b1;
                    state_d          = StWren;
                end
            end
            StWren: begin
                io_link_tx_valid = 1'b1;
                io_link_tx_bits  = io_ctrl_wren_code;
                if (io_link_tx_ready) state_d = StWend;
            end
            StWend: begin
                io_link_cs_clear = 1'b1;
                if (!io_link_active) state_d = StPcmd;
            end
            StPcmd: begin
                io_link_tx_valid = 1'b1;
                io_link_tx_bits  = io_ctrl_prog_code;
                if (io_link_tx_ready) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = {5'd0, io_ctrl_addr_len};
                    state_d      = StPaddr;
                end
            end
            StPaddr: begin
                phase_proto      = io_ctrl_proto;
                io_link_tx_valid = 1'b1;
                io_link_tx_bits  = addr_byte(addr_q, cnt_val);
                if (io_link_tx_ready) begin
                    // A zero address length is treated as a single byte
                    if (cnt_val <= 8'd1) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = len_q;
                        state_d      = StPdata;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            StPdata: begin
                phase_proto      = io_ctrl_proto;
                io_link_tx_valid = io_wdata_valid;
                io_link_tx_bits  = io_wdata_bits;
                io_wdata_ready   = io_link_tx_ready;
                if (io_wdata_valid && io_link_tx_ready) begin
                    if (cnt_last) state_d = StPend;
                    else          cnt_dec = 1'b1;
                end
            end
            StPend: begin
                io_link_cs_clear = 1'b1;
                if (!io_link_active) begin
                    poll_load = 1'b1;
                    state_d   = StSrcmd;
                end
            end
            StSrcmd: begin
                io_link_tx_valid = 1'b1;
                io_link_tx_bits  = io_ctrl_rdsr_code;
                if (io_link_tx_ready) state_d = StSrrd;
            end
            StSrrd: begin
                // Dummy tx bytes clock the status in; only rx_valid advances polling
                io_link_tx_valid  = 1'b1;
                io_link_fmt_iodir = 1'b0;
                if (io_link_rx_valid) begin
                    if (!io_link_rx_bits[WipBit]) begin
                        state_d = StSend;
                    end else if (poll_last) begin
                        timeout_d = 1'b1;
                        state_d   = StSend;
                    end else begin
                        poll_dec = 1'b1;
                    end
                end
            end
            StSend: begin
                io_link_cs_clear = 1'b1;
                if (!io_link_active) begin
                    io_done_valid = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Engine state and latched request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            timeout_q <= timeout_d;
        end
    end

    assign io_busy              = (state_q != StIdle);
    assign io_link_lock         = (state_q != StIdle);
    assign io_done_bits_timeout = timeout_q;
    assign io_link_fmt_proto    = phase_proto;
    assign io_link_cnt          = proto_cnt(phase_proto);
    assign io_link_fmt_endian   = io_ctrl_fmt_endian;
    assign io_link_cs_set       = 1'b1;
    assign io_link_cs_hold      = 1'b1;

endmodule

// File: tb/tb_n101_qspi_flashwr.sv
// Bench for the QSPI program engine: directed scenarios plus randomized
// operations, each checked against an expected byte stream built from the request.
module tb_n101_qspi_flashwr;

    localparam int PL = 4;

    logic        clock, reset_n, io_en;
    logic [1:0]  io_ctrl_proto;
    logic [2:0]  io_ctrl_addr_len;
    logic [7:0]  io_ctrl_wren_code, io_ctrl_prog_code, io_ctrl_rdsr_code;
    logic        io_ctrl_fmt_endian;
    logic        io_req_ready, io_req_valid;
    logic [31:0] io_req_bits_addr;
    logic [7:0]  io_req_bits_len;
    logic        io_wdata_ready, io_wdata_valid;
    logic [7:0]  io_wdata_bits;
    logic        io_done_valid, io_done_bits_timeout, io_busy;
    logic        io_link_tx_ready, io_link_tx_valid;
    logic [7:0]  io_link_tx_bits;
    logic        io_link_rx_valid;
    logic [7:0]  io_link_rx_bits;
    logic [7:0]  io_link_cnt;
    logic [1:0]  io_link_fmt_proto;
    logic        io_link_fmt_endian, io_link_fmt_iodir;
    logic        io_link_cs_set, io_link_cs_clear, io_link_cs_hold;
    logic        io_link_active, io_link_lock;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    n101_qspi_flashwr #(.POLL_LIMIT(PL)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .io_en                (io_en),
        .io_ctrl_proto        (io_ctrl_proto),
        .io_ctrl_addr_len     (io_ctrl_addr_len),
        .io_ctrl_wren_code    (io_ctrl_wren_code),
        .io_ctrl_prog_code    (io_ctrl_prog_code),
        .io_ctrl_rdsr_code    (io_ctrl_rdsr_code),
        .io_ctrl_fmt_endian   (io_ctrl_fmt_endian),
        .io_req_ready         (io_req_ready),
        .io_req_valid         (io_req_valid),
        .io_req_bits_addr     (io_req_bits_addr),
        .io_req_bits_len      (io_req_bits_len),
        .io_wdata_ready       (io_wdata_ready),
        .io_wdata_valid       (io_wdata_valid),
        .io_wdata_bits        (io_wdata_bits),
        .io_done_valid        (io_done_valid),
        .io_done_bits_timeout (io_done_bits_timeout),
        .io_busy              (io_busy),
        .io_link_tx_ready     (io_link_tx_ready),
        .io_link_tx_valid     (io_link_tx_valid),
        .io_link_tx_bits      (io_link_tx_bits),
        .io_link_rx_valid     (io_link_rx_valid),
        .io_link_rx_bits      (io_link_rx_bits),
        .io_link_cnt          (io_link_cnt),
        .io_link_fmt_proto    (io_link_fmt_proto),
        .io_link_fmt_endian   (io_link_fmt_endian),
        .io_link_fmt_iodir    (io_link_fmt_iodir),
        .io_link_cs_set       (io_link_cs_set),
        .io_link_cs_clear     (io_link_cs_clear),
        .io_link_cs_hold      (io_link_cs_hold),
        .io_link_active       (io_link_active),
        .io_link_lock         (io_link_lock)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete program operation with a cycle-by-cycle link model.
    // wip_reads: status reads returning WIP=1 before WIP=0; stall_at: data index
    // at which wdata is withheld for 5 cycles (-1 none); abort_nb: pulse reset
    // once that many bytes have moved (0 none).
    task automatic run_op(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] alen,
                          input logic [1:0] proto, input int wip_reads, input int stall_at,
                          input int wend_hold, input int abort_nb);
        logic [7:0] exp_q[$];
        logic [7:0] data[$];
        logic [7:0] pcnt;
        int  alen_i, n_exp, exp_reads;
        int  nb = 0, di = 0, rcount = 0, hold = 0, win = 0, done_cnt = 0, cyc = 0;
        int  err_byte = 0, err_fmt = 0, err_dummy = 0, err_end = 0, err_stall = 0, err_busy = 0;
        int  stall_left = 5;
        bit  exp_to, act, in_win = 0, prev_act = 0, in_data, stall;
        logic done_to = 1'b0;

        alen_i = int'(alen);
        exp_q.push_back(io_ctrl_wren_code);
        exp_q.push_back(io_ctrl_prog_code);
        for (int i = alen_i; i >= 1; i--) exp_q.push_back(addr[8*i-1 -: 8]);
        for (int i = 0; i <= int'(len); i++) begin
            data.push_back(8'($urandom));
            exp_q.push_back(data[i]);
        end
        exp_q.push_back(io_ctrl_rdsr_code);
        n_exp = exp_q.size();
        pcnt = (proto == 2'd0) ? 8'd8 : (proto == 2'd1) ? 8'd4 : (proto == 2'd2) ? 8'd2 : 8'd0;
        exp_to    = (wip_reads >= PL);
        exp_reads = exp_to ? PL : wip_reads + 1;

        @(negedge clock);
        io_en = 1'b1;
        io_req_valid = 1'b1;
        io_req_bits_addr = addr;
        io_req_bits_len = len;
        io_ctrl_addr_len = alen;
        io_ctrl_proto = proto;
        io_link_tx_ready = 1'b0;
        io_link_active = 1'b0;
        io_link_rx_valid = 1'b0;
        #1;
        chk("req_ready", io_req_ready, 1);
        chk("accept_cs_clear", io_link_cs_clear, 1);
        @(negedge clock);
        io_req_valid = 1'b0;
        io_en = 1'($urandom_range(0, 1));

        while (done_cnt == 0 && cyc < 4000) begin
            io_link_tx_ready = ($urandom_range(0, 9) < 6);
            in_data = (nb >= 2 + alen_i) && (nb < n_exp - 1);
            stall = in_data && (di == stall_at) && (stall_left > 0);
            io_wdata_valid = (di <= int'(len)) && !stall && ($urandom_range(0, 7) != 0);
            if (di <= int'(len)) io_wdata_bits = data[di];
            else                 io_wdata_bits = 8'($urandom);
            act = (hold > 0);
            io_link_active = act;
            if (hold > 0) hold--;
            io_link_rx_valid = (nb >= n_exp) && ($urandom_range(0, 2) == 0);
            io_link_rx_bits = {7'($urandom), (rcount < wip_reads)};
            #1;
            if (io_busy !== 1'b1 || io_link_lock !== 1'b1) err_busy++;
            if (stall) begin
                if (io_link_tx_valid !== 1'b0 || io_link_cs_clear !== 1'b0) err_stall++;
                stall_left--;
            end
            if (in_data && io_wdata_ready !== io_link_tx_ready) err_fmt++;
            // An END window persists exactly while the link reports active
            if (in_win && io_link_cs_clear !== prev_act) err_end++;
            if (io_link_cs_clear && !in_win) win++;
            if (io_link_cs_clear && io_link_tx_valid) err_end++;
            if (io_done_valid !== (io_link_cs_clear && !act && win == 3)) err_end++;
            if (io_done_valid) begin
                done_cnt++;
                done_to = io_done_bits_timeout;
            end
            in_win = io_link_cs_clear;
            prev_act = act;
            if (io_link_rx_valid && !io_link_cs_clear) rcount++;
            if (io_link_tx_valid && io_link_tx_ready) begin
                if (nb < n_exp) begin
                    if (io_link_tx_bits !== exp_q[nb]) err_byte++;
                    if (nb >= 2 && nb < n_exp - 1) begin
                        if (io_link_fmt_proto !== proto || io_link_cnt !== pcnt) err_fmt++;
                    end else if (io_link_fmt_proto !== 2'd0 || io_link_cnt !== 8'd8) begin
                        err_fmt++;
                    end
                    if (io_link_fmt_iodir !== 1'b1) err_fmt++;
                    if (in_data) di++;
                    nb++;
                    hold = (nb == 1) ? wend_hold : $urandom_range(0, 3);
                end else if (io_link_tx_bits !== 8'h00 || io_link_fmt_iodir !== 1'b0 ||
                             io_link_cnt !== 8'd8) begin
                    err_dummy++;
                end
            end
            if (abort_nb != 0 && nb == abort_nb) begin
                @(negedge clock);
                reset_n = 1'b0;
                #1;
                chk("rst_lock", io_link_lock, 0);
                chk("rst_tx_valid", io_link_tx_valid, 0);
                chk("rst_busy", io_busy, 0);
                chk("rst_req_ready", io_req_ready, io_en);
                @(negedge clock);
                reset_n = 1'b1;
                io_link_tx_ready = 1'b0;
                io_link_rx_valid = 1'b0;
                return;
            end
            cyc++;
            if (done_cnt == 0) @(negedge clock);
        end

        chk("done_count", done_cnt, 1);
        chk("done_timeout", done_to, exp_to);
        chk("tx_byte_count", nb, n_exp);
        chk("tx_byte_values", err_byte, 0);
        chk("tx_format", err_fmt, 0);
        chk("status_dummy", err_dummy, 0);
        chk("cs_windows", win, 3);
        chk("end_timing", err_end, 0);
        chk("status_reads", rcount, exp_reads);
        chk("busy_lock", err_busy, 0);
        if (stall_at >= 0) begin
            chk("stall_cycles", stall_left, 0);
            chk("stall_hold", err_stall, 0);
        end
        @(negedge clock);
        io_link_tx_ready = 1'b0;
        io_link_rx_valid = 1'b0;
        io_link_active = 1'b0;
        #1;
        chk("post_busy", io_busy, 0);
        chk("post_lock", io_link_lock, 0);
        chk("post_req_ready", io_req_ready, io_en);
    endtask

    initial begin
        reset_n = 1'b0;
        io_en = 1'b0;
        io_ctrl_proto = 2'd0;
        io_ctrl_addr_len = 3'd3;
        io_ctrl_wren_code = 8'h06;
        io_ctrl_prog_code = 8'h02;
        io_ctrl_rdsr_code = 8'h05;
        io_ctrl_fmt_endian = 1'b1;
        io_req_valid = 1'b0;
        io_req_bits_addr = 32'd0;
        io_req_bits_len = 8'd0;
        io_wdata_valid = 1'b0;
        io_wdata_bits = 8'd0;
        io_link_tx_ready = 1'b0;
        io_link_rx_valid = 1'b0;
        io_link_rx_bits = 8'd0;
        io_link_active = 1'b0;

        repeat (2) @(negedge clock);
        #1;
        chk("reset_tx_valid", io_link_tx_valid, 0);
        chk("reset_done", io_done_valid, 0);
        chk("reset_busy", io_busy, 0);
        chk("reset_lock", io_link_lock, 0);
        chk("reset_cs_clear", io_link_cs_clear, 0);
        chk("reset_req_ready_en0", io_req_ready, 0);
        chk("reset_endian", io_link_fmt_endian, 1);
        io_en = 1'b1;
        #1;
        chk("reset_req_ready_en1", io_req_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic single-lane program, one busy status then ready
        run_op(32'h0012_3456, 8'd3, 3'd3, 2'd0, 1, -1, 0, 0);
        // Quad, 4-byte address, single data byte
        run_op(32'hA1B2_C3D4, 8'd0, 3'd4, 2'd2, 0, -1, 1, 0);
        // Data starvation mid-stream
        run_op(32'h0000_4321, 8'd7, 3'd3, 2'd1, 2, 3, 2, 0);
        // Status never clears: poll budget exhausted
        run_op(32'h0001_0000, 8'd2, 3'd3, 2'd0, 10, -1, 0, 0);
        // Link stays active for 10 cycles after write-enable
        run_op(32'h0055_AA00, 8'd1, 3'd2, 2'd0, 0, -1, 10, 0);
        // Reset mid-address, then a clean operation
        run_op(32'hDEAD_BEEF, 8'd4, 3'd4, 2'd2, 0, -1, 0, 3);
        run_op(32'h0BAD_F00D, 8'd5, 3'd4, 2'd0, 3, -1, 1, 0);

        for (int k = 0; k < 6; k++) begin
            io_ctrl_wren_code = 8'($urandom);
            io_ctrl_prog_code = 8'($urandom);
            io_ctrl_rdsr_code = 8'($urandom);
            io_ctrl_fmt_endian = 1'($urandom);
            run_op($urandom, (k == 5) ? 8'd255 : 8'($urandom_range(0, 20)),
                   3'($urandom_range(1, 4)), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 5), -1, $urandom_range(0, 3), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
